io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Shares the 8-bit IO register bus (address/din/w_en/r_en/dout) between two requesters, typically the CPU port and a DMA/sequencer port. It arbitrates round-robin and issues exactly one single-cycle bus transaction per grant. Read data from the IO block arrives one cycle after r_en; the arbiter returns it to the owning master. It sits between the masters and the IO block, owns the bus signals exclusively, and guarantees no two masters ever drive a transaction in the same cycle.

## Interface
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- m0_req, m1_req  input  1  request; held high with command stable until gnt seen
- m0_addr, m1_addr  input  ADDR_W  target register address
- m0_wdata, m1_wdata  input  DATA_W  write data
- m0_we, m1_we  input  1  write strobe for the command
- m0_re, m1_re  input  1  read strobe for the command
- m0_lock, m1_lock  input  1  ownership hold (only with IO_ARB_LOCK_EN)
- m0_gnt, m1_gnt  output  1  one-cycle pulse: command captured
- m0_rdata, m1_rdata  output  DATA_W  read data, valid with rvalid
- m0_rvalid, m1_rvalid  output  1  one-cycle pulse: read data returned
- bus_addr  output  ADDR_W  to IO address
- bus_din  output  DATA_W  to IO din
- bus_w_en, bus_r_en  output  1  to IO w_en/r_en
- bus_dout  input  DATA_W  from IO dout (registered, valid 1 cycle after r_en)

## Operation
- FSM states: IDLE, ISSUE, RDWAIT. Reset state IDLE.
- IDLE: if any req high, pick winner, latch its addr/wdata/we/re into command regs, pulse winner gnt next cycle, go ISSUE. No req: stay IDLE.
- Winner: only one requesting → it wins. Both → master indicated by priority pointer `prio` (0 = m0 preferred). After each grant, `prio` points to the non-granted master. Reset value of `prio` = 0.
- ISSUE: bus_addr/bus_din = command regs, bus_w_en = cmd_we, bus_r_en = cmd_re for exactly this cycle. If cmd_re → RDWAIT, else → IDLE.
- RDWAIT: sample bus_dout into owner's rdata; owner rvalid pulses next cycle; → IDLE.
- we and re both set: both strobes issued in the same ISSUE cycle; returned data is the register value before the write (IO semantics); rvalid still returned.
- Neither we nor re set: command still granted, ISSUE drives address with both strobes 0, → IDLE.
- Outside ISSUE: bus_addr, bus_din, bus_w_en, bus_r_en all 0.
- req sampled only in IDLE; master may change command after its gnt pulse.
- Reset values: all gnt, rvalid, bus_* outputs 0; rdata 0; command regs 0.
- Reset mid-transaction (ISSUE or RDWAIT): transaction dropped, no rvalid, bus strobes 0 from next cycle, `prio` = 0.

## Timing
- Cycle 0: req high in IDLE. Cycle 1: gnt pulse, ISSUE, bus strobes active. Cycle 2: IDLE (write) or RDWAIT (read). Cycle 3 (read): rvalid + rdata.
- Throughput: write every 2 cycles, read every 3 cycles; back-to-back alternation between masters when both request.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- IO_ARB_LOCK_EN defined: in IDLE, if the last granted master has lock high, only that master is eligible (other master's req ignored, `prio` not advanced) until lock drops; lock sampled in IDLE with req. Lock low or not held by last owner → normal round-robin.
- Not defined: m0_lock/m1_lock ports present but ignored; pure round-robin.

## Test plan
- m0 write addr 0x01 data 0xA5 → m0_gnt at cycle 1; bus_addr=0x01, bus_din=0xA5, bus_w_en=1 for one cycle only; back to IDLE cycle 2.
- m1 read addr 0x02, bus_dout=0x3C in the cycle after bus_r_en → m1_rvalid single pulse at cycle 3 with m1_rdata=0x3C; m0_rvalid stays 0.
- Both req continuously with writes from reset → grants m0, m1, m0, m1 alternating every 2 cycles; never two strobes from different masters in one cycle.
- rst asserted in RDWAIT → no rvalid, all bus outputs 0 next cycle, next simultaneous request granted to m0.
- Simultaneous we+re on 0x05 holding 0x11, wdata 0x22 → bus_w_en and bus_r_en together, rdata 0x11.
- IO_ARB_LOCK_EN: m0 lock+req held, m1 req held → four consecutive m0 grants; drop m0_lock → next grant m1.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sharing the IO register bus between two masters
//   Optional feature macro: IO_ARB_LOCK_EN (last owner holding lock stays sole eligible master)
//   Ports:
//     clk, rst                                  clock, synchronous active-high reset
//     mN_req/addr/wdata/we/re/lock              master N command, held until mN_gnt
//     mN_gnt                                    one-cycle pulse: command captured
//     mN_rdata, mN_rvalid                       read return, rvalid pulses once per read
//     bus_addr, bus_din, bus_w_en, bus_r_en     IO bus drive, nonzero only in the issue cycle
//     bus_dout                                  IO read data, valid the cycle after bus_r_en
module io_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic              m0_re,
    input  logic              m0_lock,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic              m1_re,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_din,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [DATA_W-1:0] bus_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
    state_t state, state_n;
    logic prio, owner, hold, req0, req1, grant, win, cmd_re;
    logic gnt0_n, gnt1_n, rv0_n, rv1_n, w_en_n, r_en_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n;
`ifdef IO_ARB_LOCK_EN
    logic owned;
    always_ff @(posedge clk)
        owned <= rst ? 1'b0 : (owned | grant);
    assign hold = owned & (owner ? m1_lock : m0_lock);
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign hold = 1'b0;
`endif
    // A held lock masks the other master out of arbitration entirely.
    assign req0  = m0_req & ~(hold & owner);
    assign req1  = m1_req & ~(hold & ~owner);
    assign grant = (state == IDLE) & (req0 | req1);
    assign win   = (req0 & req1) ? prio : req1;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = grant ? ISSUE : (state == ISSUE && cmd_re) ? RDWAIT : IDLE;
    end
    // Next values of the output registers; the bus registers hold the captured
    // command for exactly the ISSUE cycle and are zero otherwise.
    always_comb begin
        gnt0_n = grant & ~win;
        gnt1_n = grant & win;
        addr_n = grant ? (win ? m1_addr : m0_addr) : '0;
        din_n  = grant ? (win ? m1_wdata : m0_wdata) : '0;
        w_en_n = grant & (win ? m1_we : m0_we);
        r_en_n = grant & (win ? m1_re : m0_re);
        rv0_n  = (state == RDWAIT) & ~owner;
        rv1_n  = (state == RDWAIT) & owner;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            bus_addr  <= '0;
            bus_din   <= '0;
            bus_w_en  <= 1'b0;
            bus_r_en  <= 1'b0;
            cmd_re    <= 1'b0;
            owner     <= 1'b0;
            prio      <= 1'b0;
        end else begin
            m0_gnt    <= gnt0_n;
            m1_gnt    <= gnt1_n;
            m0_rvalid <= rv0_n;
            m1_rvalid <= rv1_n;
            bus_addr  <= addr_n;
            bus_din   <= din_n;
            bus_w_en  <= w_en_n;
            bus_r_en  <= r_en_n;
            if (rv0_n) m0_rdata <= bus_dout;
            if (rv1_n) m1_rdata <= bus_dout;
            if (grant) begin
                cmd_re <= r_en_n;
                owner  <= win;
                if (!hold) prio <= ~win;
            end
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized self-checking bench against a transaction-timeline model
`timescale 1ns/1ps
module tb_io_bus_arbiter;
    localparam int NC = 4096;
    logic clk = 1'b0, rst;
    logic m0_req, m1_req, m0_we, m1_we, m0_re, m1_re, m0_lock, m1_lock;
    logic [7:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_w_en, bus_r_en;
    logic [7:0] m0_rdata, m1_rdata, bus_addr, bus_din, bus_dout;

    io_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_re(m0_re), .m0_lock(m0_lock),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_re(m1_re), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_w_en(bus_w_en), .bus_r_en(bus_r_en),
        .bus_dout(bus_dout)
    );

    always #5 clk = ~clk;

    // IO register block: registered read of the pre-write value, garbage when not reading.
    bit [7:0] io_mem [256];
    always @(posedge clk) begin
        bus_dout <= bus_r_en ? io_mem[bus_addr] : 8'($urandom);
        if (bus_w_en) io_mem[bus_addr] <= bus_din;
    end

    int cyc, n_chk, n_pass, free_at, mode;
    bit prio, owner, owned, rst_v;
    bit [7:0] mmem [256];
    bit e_g0[NC], e_g1[NC], e_we[NC], e_re[NC], e_v0[NC], e_v1[NC];
    bit [7:0] e_a[NC], e_d[NC], e_r0[NC], e_r1[NC];
    bit p_req[2], p_we[2], p_re[2], p_lock[2];
    bit [7:0] p_addr[2], p_wd[2];
    int g_cyc[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk)
        if (cyc >= 1)
            chk($sformatf("cycle %0d outputs", cyc),
                64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, bus_addr, bus_din, bus_w_en, bus_r_en}),
                64'({e_g0[cyc], e_g1[cyc], e_v0[cyc], e_v1[cyc], e_r0[cyc], e_r1[cyc], e_a[cyc], e_d[cyc], e_we[cyc], e_re[cyc]}));

    task automatic set_cmd(input int m, input bit we, input bit re, input bit [7:0] a, input bit [7:0] d);
        p_req[m] = 1'b1; p_we[m] = we; p_re[m] = re; p_addr[m] = a; p_wd[m] = d;
    endtask

    task automatic new_cmd(input int m, input bit we, input bit re);
        set_cmd(m, we, re, 8'($urandom_range(0, 7)), 8'($urandom));
    endtask

    // Masters release their command the cycle after they see their grant.
    task automatic masters_update();
        for (int m = 0; m < 2; m++) begin
            if (g_cyc[m] == cyc - 1) begin
                p_req[m] = 1'b0;
                if (mode == 1) new_cmd(m, 1'b1, 1'b0);
            end
            if (mode == 2) begin
                if (!p_req[m] && $urandom_range(0, 2) == 0) new_cmd(m, 1'($urandom), 1'($urandom));
                p_lock[m] = $urandom_range(0, 3) != 0;
            end
        end
    endtask

    task automatic drive();
        rst = rst_v;
        m0_req = p_req[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0]; m0_we = p_we[0]; m0_re = p_re[0]; m0_lock = p_lock[0];
        m1_req = p_req[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1]; m1_we = p_we[1]; m1_re = p_re[1]; m1_lock = p_lock[1];
    endtask

    // Timeline model: a grant decided in cycle c shows gnt and the bus in c+1,
    // frees the arbiter at c+2 (write) or c+3 (read), and returns read data in c+3.
    task automatic model_cycle();
        int c = cyc;
        if (rst_v) begin
            for (int k = 1; k <= 3; k++) begin
                e_g0[c+k] = 0; e_g1[c+k] = 0; e_we[c+k] = 0; e_re[c+k] = 0;
                e_a[c+k] = 0; e_d[c+k] = 0; e_v0[c+k] = 0; e_v1[c+k] = 0;
            end
            e_r0[c+1] = 0; e_r1[c+1] = 0;
            free_at = c + 1; prio = 0; owned = 0;
            return;
        end
        if (c >= free_at) begin
            bit hold, r0, r1, w;
`ifdef IO_ARB_LOCK_EN
            hold = owned && p_lock[owner];
`else
            hold = 0;
`endif
            r0 = p_req[0] && !(hold && owner);
            r1 = p_req[1] && !(hold && !owner);
            if (r0 || r1) begin
                w = (r0 && r1) ? prio : r1;
                if (w) e_g1[c+1] = 1; else e_g0[c+1] = 1;
                e_a[c+1] = p_addr[w]; e_d[c+1] = p_wd[w]; e_we[c+1] = p_we[w]; e_re[c+1] = p_re[w];
                if (p_re[w]) begin
                    if (w) begin e_v1[c+3] = 1; e_r1[c+3] = mmem[p_addr[w]]; end
                    else begin e_v0[c+3] = 1; e_r0[c+3] = mmem[p_addr[w]]; end
                end
                if (p_we[w]) mmem[p_addr[w]] = p_wd[w];
                if (!hold) prio = !w;
                owner = w; owned = 1; g_cyc[w] = c + 1;
                free_at = c + (p_re[w] ? 3 : 2);
            end
        end
        if (!e_v0[c+1]) e_r0[c+1] = e_r0[c];
        if (!e_v1[c+1]) e_r1[c+1] = e_r1[c];
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        masters_update();
        drive();
        model_cycle();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        g_cyc[0] = -10; g_cyc[1] = -10;
        mode = 0; rst_v = 1; cyc = 0; free_at = 0;
        drive();
        model_cycle();
        steps(2);
        rst_v = 0;
        step();
        chk("reset strobes", 64'({m0_gnt, m1_gnt, bus_w_en, bus_r_en, m0_rvalid, m1_rvalid}), 64'(0));
        chk("reset bus", 64'({bus_addr, bus_din}), 64'(0));
        chk("reset rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
        // m0 write 0x01 <- 0xA5
        set_cmd(0, 1, 0, 8'h01, 8'hA5);
        steps(2);
        chk("m0 write gnt", 64'({m0_gnt, m1_gnt}), 64'(2'b10));
        chk("m0 write bus", 64'({bus_addr, bus_din, bus_w_en, bus_r_en}), 64'({8'h01, 8'hA5, 2'b10}));
        step();
        chk("m0 write one cycle", 64'({m0_gnt, bus_w_en, bus_addr, bus_din}), 64'(0));
        // preload 0x02 <- 0x3C, then m1 reads it back
        set_cmd(0, 1, 0, 8'h02, 8'h3C);
        steps(3);
        set_cmd(1, 0, 1, 8'h02, 8'h00);
        steps(2);
        chk("m1 read issue", 64'({m1_gnt, bus_r_en, bus_w_en, bus_addr}), 64'({3'b110, 8'h02}));
        steps(2);
        chk("m1 read return", 64'({m1_rvalid, m1_rdata, m0_rvalid}), 64'({1'b1, 8'h3C, 1'b0}));
        step();
        chk("m1 rvalid pulse", 64'({m1_rvalid, m0_rvalid}), 64'(0));
        // both masters writing continuously from reset alternate m0, m1, m0, m1
        rst_v = 1; step(); rst_v = 0;
        mode = 1; new_cmd(0, 1, 0); new_cmd(1, 1, 0);
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) chk($sformatf("rr grant %0d", k), 64'({m0_gnt, m1_gnt}), 64'((k % 4 == 1) ? 2'b10 : 2'b01));
        end
        mode = 0;
        steps(8);
        // reset during RDWAIT drops the read and restores m0 preference
        set_cmd(0, 0, 1, 8'h01, 8'h00);
        steps(2);
        rst_v = 1; step(); rst_v = 0;
        set_cmd(0, 1, 0, 8'h03, 8'h44); set_cmd(1, 1, 0, 8'h04, 8'h55);
        step();
        chk("rst in rdwait quiet", 64'({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, bus_w_en, bus_r_en, bus_addr, bus_din}), 64'(0));
        step();
        chk("post-reset grant m0", 64'({m0_gnt, m1_gnt}), 64'(2'b10));
        steps(8);
        // simultaneous we+re returns the pre-write value
        set_cmd(0, 1, 0, 8'h05, 8'h11);
        steps(4);
        set_cmd(1, 1, 1, 8'h05, 8'h22);
        steps(2);
        chk("we+re strobes", 64'({bus_w_en, bus_r_en, bus_addr, bus_din}), 64'({2'b11, 8'h05, 8'h22}));
        steps(2);
        chk("we+re old data", 64'({m1_rvalid, m1_rdata}), 64'({1'b1, 8'h11}));
        steps(4);
`ifdef IO_ARB_LOCK_EN
        rst_v = 1; step(); rst_v = 0;
        mode = 1; p_lock[0] = 1; new_cmd(0, 1, 0); new_cmd(1, 1, 0);
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k % 2 == 1) chk($sformatf("lock grant %0d", k), 64'({m0_gnt, m1_gnt}), 64'(2'b10));
        end
        p_lock[0] = 0;
        steps(2);
        chk("unlock grant m1", 64'({m0_gnt, m1_gnt}), 64'(2'b01));
        mode = 0;
        steps(8);
`endif
        mode = 2;
        for (int i = 0; i < 2500; i++) begin
            rst_v = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_v = 0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
